// File: rtl/exe_result_fifo_pkg.sv
// Shared payload types for the ALU issue queue, the result FIFO and the CDB arbiter.
package exe_result_fifo_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ROB_ID_W = 4;

  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  typedef struct packed {
    word_t   result;
    rob_id_t rob_id;
    logic    jump;
    word_t   target;
  } exe_result_t;

endpackage

// File: rtl/exe_result_fifo.sv
// In-order result buffer between the ALU issue queue and the CDB / ROB writeback port.
// Optional EXE_RESULT_FIFO_BYPASS_EN: zero-latency pass-through when the buffer is empty.
module exe_result_fifo
  import exe_result_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  word_t          in_result_i,
  input  rob_id_t        in_rob_id_i,
  input  logic           in_jump_i,
  input  word_t          in_target_i,
  output logic           cdb_valid_o,
  input  logic           cdb_ready_i,
  output word_t          cdb_result_o,
  output rob_id_t        cdb_rob_id_o,
  output logic           cdb_jump_o,
  output word_t          cdb_target_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  exe_result_t      mem [DEPTH];
  exe_result_t      in_entry;
  exe_result_t      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             bypass_valid;
  logic             bypass_take;
  logic             wr_en;
  logic             rd_en;

  assign in_entry = '{result: in_result_i, rob_id: in_rob_id_i,
                      jump: in_jump_i, target: in_target_i};

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign in_ready_o = !full;
  assign push       = in_valid_i & in_ready_o;

`ifdef EXE_RESULT_FIFO_BYPASS_EN
  assign bypass_valid = empty & in_valid_i & !flush;
`else
  assign bypass_valid = 1'b0;
`endif

  assign cdb_valid_o = !empty | bypass_valid;
  assign pop         = cdb_valid_o & cdb_ready_i;

  // A bypassed entry consumed this cycle never touches storage or pointers.
  assign bypass_take = bypass_valid & cdb_ready_i;
  assign wr_en       = push & !flush & !bypass_take;
  assign rd_en       = pop & !flush & !bypass_take;

  always_comb begin
    head = '0;
    if (bypass_valid) begin
      head = in_entry;
    end else if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign cdb_result_o = head.result;
  assign cdb_rob_id_o = head.rob_id;
  assign cdb_jump_o   = head.jump;
  assign cdb_target_o = head.target;
  assign count_o      = count;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));

endmodule

// File: tb/tb_exe_result_fifo.sv
// Directed self-checking bench for exe_result_fifo (default build, no bypass).
module tb_exe_result_fifo;
  import exe_result_fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid_i;
  logic       in_ready_o;
  word_t      in_result_i;
  rob_id_t    in_rob_id_i;
  logic       in_jump_i;
  word_t      in_target_i;
  logic       cdb_valid_o;
  logic       cdb_ready_i;
  word_t      cdb_result_o;
  rob_id_t    cdb_rob_id_o;
  logic       cdb_jump_o;
  word_t      cdb_target_o;
  logic [2:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;

  exe_result_fifo #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_result_i  (in_result_i),
    .in_rob_id_i  (in_rob_id_i),
    .in_jump_i    (in_jump_i),
    .in_target_i  (in_target_i),
    .cdb_valid_o  (cdb_valid_o),
    .cdb_ready_i  (cdb_ready_i),
    .cdb_result_o (cdb_result_o),
    .cdb_rob_id_o (cdb_rob_id_o),
    .cdb_jump_o   (cdb_jump_o),
    .cdb_target_o (cdb_target_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input word_t r, input rob_id_t id);
    in_valid_i  = v;
    in_result_i = r;
    in_rob_id_i = id;
    in_jump_i   = 1'b0;
    in_target_i = '0;
  endtask

  initial begin
    int q[$];
    int sent;
    int rcvd;
    bit rdy;
    bit exp_push;
    bit exp_pop;

    rst_n       = 1'b0;
    flush       = 1'b0;
    cdb_ready_i = 1'b0;
    drive(1'b0, '0, '0);
    #22;

    // 1: reset state
    chk("rst_ready", in_ready_o, 1);
    chk("rst_valid", cdb_valid_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_data",  cdb_result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_count", count_o, 0);

    // 2: single push, one cycle latency, popped while ready
    drive(1'b1, 32'h11, 4'd3);
    in_jump_i   = 1'b1;
    in_target_i = 32'h1000;
    cdb_ready_i = 1'b1;
    chk("lat_no_bypass", cdb_valid_o, 0);
    tick();
    drive(1'b0, '0, '0);
    chk("p1_valid",  cdb_valid_o, 1);
    chk("p1_result", cdb_result_o, 32'h11);
    chk("p1_rob",    cdb_rob_id_o, 3);
    chk("p1_jump",   cdb_jump_o, 1);
    chk("p1_target", cdb_target_o, 32'h1000);
    chk("p1_count",  count_o, 1);
    tick();
    chk("p1_pop_count", count_o, 0);
    chk("p1_pop_valid", cdb_valid_o, 0);

    // 3/4: fill under back-pressure, full+pop refuses push, then drain in order
    cdb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0 + i, rob_id_t'(i));
      tick();
      chk("fill_count", count_o, i + 1);
    end
    chk("full_ready", in_ready_o, 0);
    chk("full_head",  cdb_result_o, 32'hA0);
    drive(1'b1, 32'hA4, 4'd4);
    tick();
    chk("held_count", count_o, 4);
    chk("held_head",  cdb_result_o, 32'hA0);
    cdb_ready_i = 1'b1;
    chk("no_comb_ready", in_ready_o, 0);
    tick();
    chk("fullpop_count", count_o, 3);
    chk("fullpop_head",  cdb_result_o, 32'hA1);
    chk("fullpop_ready", in_ready_o, 1);
    tick();
    drive(1'b0, '0, '0);
    chk("pushpop_count", count_o, 3);
    chk("pushpop_head",  cdb_result_o, 32'hA2);
    tick();
    chk("drain_a3", cdb_result_o, 32'hA3);
    chk("drain_c2", count_o, 2);
    tick();
    chk("drain_a4",  cdb_result_o, 32'hA4);
    chk("drain_rob", cdb_rob_id_o, 4);
    tick();
    chk("drain_empty", cdb_valid_o, 0);
    chk("drain_c0",    count_o, 0);

    // 5: flush with a simultaneous push
    cdb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hB0 + i, rob_id_t'(i));
      tick();
    end
    chk("pre_flush_count", count_o, 3);
    drive(1'b1, 32'hB3, 4'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("flush_count", count_o, 0);
    chk("flush_valid", cdb_valid_o, 0);
    chk("flush_ready", in_ready_o, 1);
    tick();
    chk("flush_lost", count_o, 0);

    // 6: streaming with ready toggling, pointers wrap
    sent = 0;
    rcvd = 0;
    rdy  = 1'b1;
    for (int cyc = 0; cyc < 80 && rcvd < 12; cyc++) begin
      drive(sent < 12, 32'hC0 + sent, rob_id_t'(sent));
      cdb_ready_i = rdy;
      exp_push = (sent < 12) && (q.size() != 4);
      exp_pop  = (q.size() != 0) && rdy;
      chk("st_count", count_o, q.size());
      chk("st_ready", in_ready_o, q.size() != 4);
      chk("st_valid", cdb_valid_o, q.size() != 0);
      if (exp_pop) begin
        chk("st_result", cdb_result_o, 32'hC0 + q[0]);
        chk("st_rob",    cdb_rob_id_o, rob_id_t'(q[0]));
      end
      tick();
      if (exp_pop) begin
        void'(q.pop_front());
        rcvd++;
      end
      if (exp_push) begin
        q.push_back(sent);
        sent++;
      end
      rdy = !rdy;
    end
    drive(1'b0, '0, '0);
    chk("st_all_out",  rcvd, 12);
    chk("st_end_count", count_o, 0);

    // Asynchronous reset mid-cycle
    cdb_ready_i = 1'b0;
    drive(1'b1, 32'hD0, 4'd1);
    tick();
    drive(1'b0, '0, '0);
    chk("pre_arst_count", count_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_valid", cdb_valid_o, 0);
    chk("arst_data",  cdb_result_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_arst_count", count_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
